// File: rtl/unpack_cm_msg_extract_pkg.sv
// Shared constants, FSM state type and bus widths for the message-extraction block.
package saber_dec_pkg;

    localparam int unsigned SABER_EP = 10;
    localparam int unsigned SABER_ET = 4;
    localparam int unsigned SABER_EQ = 13;
    localparam int unsigned H2_DEFAULT = (1 << (SABER_EP - 2)) - (1 << (SABER_EP - SABER_ET - 1))
                                       + (1 << (SABER_EQ - SABER_EP - 1));

    localparam int unsigned V_WORDS   = 64;
    localparam int unsigned MSG_WORDS = 4;
    localparam int unsigned LANES     = 4;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned LANE_W    = DATA_W / LANES;
    localparam int unsigned ADDR_W    = 9;

    typedef enum logic [3:0] {
        IDLE, CM_ADDR, CM_LOAD, V0, V1, V2, V3, V4, CHK, WRITE, DONE
    } state_e;

endpackage

// File: rtl/unpack_cm_msg_extract_if.sv
// BRAM read/write and start/done signals of the message-extraction block.
interface unpack_cm_msg_extract_if
    import saber_dec_pkg::*;
;
    logic              start;
    logic              read_base_sel;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] read_data;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic              done;

    modport slave (
        input  start, read_data,
        output read_base_sel, read_address, write_address, write_data, write_en, done
    );

    modport master (
        output start, read_data,
        input  read_base_sel, read_address, write_address, write_data, write_en, done
    );

endinterface

// File: rtl/unpack_cm_msg_extract_msg_bit_extract.sv
// Four parallel lanes of m' = ((v + h2 - (cm << (EP-ET))) mod 2^EP) >> (EP-1).
module msg_bit_extract
    import saber_dec_pkg::*;
#(
    parameter int unsigned EP = SABER_EP,
    parameter int unsigned ET = SABER_ET
) (
    input  logic [LANES-1:0][EP-1:0] v_i,
    input  logic [LANES-1:0][ET-1:0] cm_i,
    input  logic [EP-1:0]            h2_i,
    output logic [LANES-1:0]         m_o
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [EP-1:0] t;
        // Wrap-around at EP bits is the mod 2^EP of the rounding formula.
        assign t      = v_i[l] + h2_i - {cm_i[l], {(EP - ET){1'b0}}};
        assign m_o[l] = 1'(t >> (EP - 1));
    end

endmodule

// File: rtl/unpack_cm_msg_extract.sv
// Recovers the 256-bit message from v and packed 4-bit cm, writing it as four 64-bit words.
// Define H2_PORT_EN to take the rounding constant from input h2_in instead of parameter H2.
module unpack_cm_msg_extract
    import saber_dec_pkg::*;
#(
    parameter int unsigned EP       = SABER_EP,
    parameter int unsigned ET       = SABER_ET,
    parameter int unsigned H2       = H2_DEFAULT,
    parameter int unsigned CM_BASE  = 0,
    parameter int unsigned OUT_BASE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef H2_PORT_EN
    input  logic [EP-1:0]          h2_in,
`endif
    unpack_cm_msg_extract_if.slave bus
);

    state_e                           state_q, state_d;
    logic [6:0]                       v_addr_q, v_addr_d;
    logic [$clog2(MSG_WORDS+1)-1:0]   out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]                cm_buf_q, msg_buf_q;
    logic                             load_cm, process, read_sel;
    logic [LANES-1:0][EP-1:0]         v_lanes;
    logic [LANES-1:0][ET-1:0]         cm_lanes;
    logic [LANES-1:0]                 lane_bits;
    logic [EP-1:0]                    h2_sel;

`ifdef H2_PORT_EN
    assign h2_sel = h2_in;
`else
    assign h2_sel = EP'(H2);
`endif

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            v_lanes[l]  = bus.read_data[LANE_W*l +: EP];
            cm_lanes[l] = cm_buf_q[ET*l +: ET];
        end
    end

    msg_bit_extract #(.EP(EP), .ET(ET)) u_extract (
        .v_i  (v_lanes),
        .cm_i (cm_lanes),
        .h2_i (h2_sel),
        .m_o  (lane_bits)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        v_addr_d  = v_addr_q;
        out_cnt_d = out_cnt_q;
        wr_addr_d = wr_addr_q;
        load_cm   = 1'b0;
        process   = 1'b0;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CM_ADDR;
            CM_ADDR: state_d = CM_LOAD;
            CM_LOAD: begin
                load_cm = 1'b1;
                state_d = V0;
            end
            V0: begin
                v_addr_d = v_addr_q + 7'd1;
                state_d  = V1;
            end
            V1, V2, V3: begin
                process  = 1'b1;
                v_addr_d = v_addr_q + 7'd1;
                state_d  = (state_q == V1) ? V2 : (state_q == V2) ? V3 : V4;
            end
            V4: begin
                process = 1'b1;
                state_d = CHK;
            end
            CHK:     state_d = (v_addr_q[3:0] == 4'd0) ? WRITE : CM_ADDR;
            WRITE: begin
                wr_addr_d = wr_addr_q + 1'b1;
                out_cnt_d = out_cnt_q + 1'b1;
                state_d   = (v_addr_q == 7'(V_WORDS)) ? DONE : CM_ADDR;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            v_addr_q  <= '0;
            out_cnt_q <= '0;
            wr_addr_q <= ADDR_W'(OUT_BASE);
        end else begin
            state_q   <= state_d;
            v_addr_q  <= v_addr_d;
            out_cnt_q <= out_cnt_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // NOTE: data buffers are not reset; every bit is overwritten before it reaches write_data.
    always_ff @(posedge clk) begin
        if (load_cm) begin
            cm_buf_q <= bus.read_data;
        end else if (process) begin
            cm_buf_q <= cm_buf_q >> (LANES * ET);
        end
        if (process) begin
            msg_buf_q <= {lane_bits, msg_buf_q[DATA_W-1:LANES]};
        end
    end

    assign read_sel          = (state_q == CM_ADDR);
    assign bus.read_base_sel = read_sel;
    assign bus.read_address  = read_sel ? ADDR_W'(CM_BASE) + ADDR_W'(v_addr_q[5:2])
                                        : ADDR_W'(v_addr_q);
    assign bus.write_en      = (state_q == WRITE);
    assign bus.write_data    = msg_buf_q;
    assign bus.write_address = wr_addr_q;
    assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_unpack_cm_msg_extract.sv
// Scoreboard bench: stimulus queues expected writes, a negedge monitor checks each write_en pulse.
module tb_unpack_cm_msg_extract;
    import saber_dec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unpack_cm_msg_extract_if bus ();

    unpack_cm_msg_extract dut (
        .clk   (clk),
        .rst   (rst),
`ifdef H2_PORT_EN
        .h2_in (10'd228),
`endif
        .bus   (bus)
    );

    logic [63:0] v_mem  [64];
    logic [63:0] cm_mem [16];

    // BRAM model: data one cycle after the address.
    always @(posedge clk) begin
        bus.read_data <= bus.read_base_sel ? cm_mem[4'(bus.read_address)] : v_mem[6'(bus.read_address)];
    end

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0]  exp_addr_q [$];
    logic [63:0] exp_data_q [$];
    int          exp_cyc_q  [$];
    logic [63:0] exp_words  [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle 1 is the cycle that follows the edge sampling start.
    logic [8:0]  mon_addr;
    logic [63:0] mon_data;
    int          mon_cyc;
    always @(negedge clk) begin
        if (!rst && bus.write_en) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected write_en", {63'd0, bus.write_en}, 64'd0);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                mon_cyc  = exp_cyc_q.pop_front();
                check("write_address", 64'(bus.write_address), 64'(mon_addr));
                check("write_data", bus.write_data, mon_data);
                check("write cycle", 64'(cyc - start_cyc + 1), 64'(mon_cyc));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic push_expected(input int n_words);
        for (int w = 0; w < n_words; w++) begin
            exp_addr_q.push_back(9'(w));
            exp_data_q.push_back(exp_words[w]);
            exp_cyc_q.push_back(33 * (w + 1));
        end
    endtask

    task automatic run_op(input string name);
        int n;
        push_expected(4);
        pulse_start();
        n = 0;
        while (!bus.done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, " done cycle"}, 64'(cyc - start_cyc + 1), 64'd133);
        check({name, " writes outstanding"}, 64'(exp_data_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic fill(input logic [63:0] v_word, input logic [63:0] cm_word);
        for (int a = 0; a < 64; a++) v_mem[a] = v_word;
        for (int c = 0; c < 16; c++) cm_mem[c] = cm_word;
    endtask

    task automatic set_all_expected(input logic [63:0] word);
        for (int w = 0; w < 4; w++) exp_words[w] = word;
    endtask

    task automatic round_trip();
        logic [255:0] msg;
        int vp, noise, cmk, vk;
        for (int i = 0; i < 256; i++) msg[i] = 1'($urandom_range(0, 1));
        for (int k = 0; k < 256; k++) begin
            vp    = int'($urandom_range(0, 1023));
            noise = int'($urandom_range(0, 62)) - 31;
            cmk   = ((vp + 4 + 512 * int'(msg[k])) % 1024) >> 6;
            vk    = (vp + noise + 1024) % 1024;
            v_mem[k / 4][16 * (k % 4) +: 16]   = 16'(vk);
            cm_mem[k / 16][4 * (k % 16) +: 4]  = 4'(cmk);
        end
        for (int w = 0; w < 4; w++) exp_words[w] = msg[64 * w +: 64];
    endtask

    initial begin
        bus.start = 1'b0;
        fill('0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset done", {63'd0, bus.done}, 64'd0);
        check("reset write_en", {63'd0, bus.write_en}, 64'd0);
        check("reset write_address", 64'(bus.write_address), 64'd0);
        check("reset read_base_sel", {63'd0, bus.read_base_sel}, 64'd0);
        check("reset read_address", 64'(bus.read_address), 64'd0);

        fill('0, '0);
        set_all_expected(64'h0000_0000_0000_0000);
        run_op("zeros");

        // start in DONE is ignored: done stays high and the monitor sees no write.
        pulse_start();
        repeat (10) @(negedge clk);
        check("done sticky", {63'd0, bus.done}, 64'd1);

        do_reset();
        fill({4{16'h0200}}, '0);
        set_all_expected(64'hFFFF_FFFF_FFFF_FFFF);
        run_op("v=0x200");

        do_reset();
        fill({16'd284, 16'd283, 16'd284, 16'd283}, '0);
        set_all_expected(64'hAAAA_AAAA_AAAA_AAAA);
        run_op("rounding edge");

        do_reset();
        fill({16'hFC00 | 16'd284, 16'hFC00 | 16'd283, 16'hFC00 | 16'd284, 16'hFC00 | 16'd283}, '0);
        set_all_expected(64'hAAAA_AAAA_AAAA_AAAA);
        run_op("upper v bits");

        do_reset();
        fill('0, {16{4'h8}});
        set_all_expected(64'hFFFF_FFFF_FFFF_FFFF);
        run_op("cm=8");

        do_reset();
        fill('0, {16{4'h4}});
        set_all_expected(64'hFFFF_FFFF_FFFF_FFFF);
        run_op("cm=4");

        for (int r = 0; r < 2; r++) begin
            do_reset();
            round_trip();
            run_op("round trip");
        end

        // Abort at cycle 50: only the first word may be written.
        do_reset();
        fill({16'd284, 16'd283, 16'd284, 16'd283}, '0);
        set_all_expected(64'hAAAA_AAAA_AAAA_AAAA);
        push_expected(1);
        pulse_start();
        while (cyc - start_cyc + 1 < 50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort done", {63'd0, bus.done}, 64'd0);
        check("abort write_address", 64'(bus.write_address), 64'd0);
        check("abort read_address", 64'(bus.read_address), 64'd0);
        check("abort first word written", 64'(exp_data_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_cyc_q.delete();
        repeat (80) @(negedge clk);
        check("abort stays idle", {63'd0, bus.read_base_sel}, 64'd0);
        run_op("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
